// File: rtl/keypad_timer.sv
// Microwave cook-time entry and countdown: BCD digits shift in from the keypad
// encoder, then count down MM:SS on a 1 Hz tick and report completion.
module keypad_timer (
  input  logic       clock,
  input  logic       resetn,
  input  logic [3:0] digit,
  input  logic       loadn,
  input  logic       startn,
  input  logic       stopn,
  input  logic       clearn,
  input  logic       tick,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       done,
  output logic       enablen
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       loadn_q;
  logic [3:0] min_tens_q, min_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d;
  logic [3:0] sec_ones_q, sec_ones_d;
  logic       running_q, running_d;
  logic       done_q, done_d;
  logic       enablen_q, enablen_d;

  // Key handshake: loadn is an active-low level that stays low for the whole
  // press; digit is valid only while loadn=0. A press is accepted once, on the
  // first cycle loadn is low after a cycle where it was high (loadn_q=1).
  logic press;
  logic capture;
  logic time_zero;
  logic [3:0] dec_mt, dec_mo, dec_st, dec_so;
  logic dec_zero;

  assign press     = !loadn && loadn_q;
  assign capture   = press && (digit <= 4'd9);
  assign time_zero = (min_tens_q == 4'd0) && (min_ones_q == 4'd0) &&
                     (sec_tens_q == 4'd0) && (sec_ones_q == 4'd0);

  // BCD borrow chain; sec_tens above 5 is simply decremented like any digit.
  always_comb begin
    dec_mt = min_tens_q;
    dec_mo = min_ones_q;
    dec_st = sec_tens_q;
    dec_so = sec_ones_q;
    if (sec_ones_q != 4'd0) begin
      dec_so = sec_ones_q - 4'd1;
    end else begin
      dec_so = 4'd9;
      if (sec_tens_q != 4'd0) begin
        dec_st = sec_tens_q - 4'd1;
      end else begin
        dec_st = 4'd5;
        if (min_ones_q != 4'd0) begin
          dec_mo = min_ones_q - 4'd1;
        end else begin
          dec_mo = 4'd9;
          dec_mt = min_tens_q - 4'd1;
        end
      end
    end
    dec_zero = (dec_mt == 4'd0) && (dec_mo == 4'd0) &&
               (dec_st == 4'd0) && (dec_so == 4'd0);
  end

  // Next-state and time datapath
  always_comb begin
    state_d    = state_q;
    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!clearn) begin
          min_tens_d = 4'd0;
          min_ones_d = 4'd0;
          sec_tens_d = 4'd0;
          sec_ones_d = 4'd0;
        end else if (capture) begin
          min_tens_d = min_ones_q;
          min_ones_d = sec_tens_q;
          sec_tens_d = sec_ones_q;
          sec_ones_d = digit;
        end else if (!startn && !time_zero) begin
          state_d = ST_RUNNING;
        end
      end
      ST_RUNNING: begin
        if (!stopn) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          min_tens_d = dec_mt;
          min_ones_d = dec_mo;
          sec_tens_d = dec_st;
          sec_ones_d = dec_so;
          if (dec_zero) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!clearn || !stopn) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state so the registered flags track the state
  always_comb begin
    running_d = (state_d == ST_RUNNING);
    done_d    = (state_d == ST_DONE);
    enablen_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      loadn_q    <= 1'b1;
      min_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      sec_ones_q <= 4'd0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      enablen_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      loadn_q    <= loadn;
      min_tens_q <= min_tens_d;
      min_ones_q <= min_ones_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
      running_q  <= running_d;
      done_q     <= done_d;
      enablen_q  <= enablen_d;
    end
  end

  assign min_tens = min_tens_q;
  assign min_ones = min_ones_q;
  assign sec_tens = sec_tens_q;
  assign sec_ones = sec_ones_q;
  assign running  = running_q;
  assign done     = done_q;
  assign enablen  = enablen_q;

endmodule

// File: doc/keypad_timer.md
# keypad_timer

Consumes the `digit`/`loadn` pair produced by the keypad priority encoder and builds the microwave cook time as four BCD digits (MM:SS). Digits shift in from the right, one per key press. The block then counts the time down on a 1 Hz tick and flags completion. It drives the encoder's `enablen`, so keypad entry is locked out while the oven runs or sits in the done state.

## Interface
- Parameters: none.
- `clock`  in  1  system clock, all logic on rising edge
- `resetn`  in  1  synchronous, active-low reset
- `digit`  in  4  BCD key value from encoder; valid only while `loadn`=0
- `loadn`  in  1  active-low key-present level; held low for the whole press
- `startn`  in  1  active-low start request, level-sampled
- `stopn`  in  1  active-low stop/pause request, level-sampled
- `clearn`  in  1  active-low clear request, level-sampled
- `tick`  in  1  one-cycle-wide 1 Hz enable
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones`  out  4 each  displayed time, BCD
- `running`  out  1  high in RUNNING
- `done`  out  1  high in DONE (level)
- `enablen`  out  1  to encoder: 0 = keypad enabled (IDLE only), 1 = disabled

## Operation
- Reset, while `resetn`=0 at a clock edge:
  - all four digits = 0; state = IDLE; `running`=0; `done`=0; `enablen`=0.
  - Internal `loadn_q` = 1.
- Key capture:
  - A press is `loadn`=0 while `loadn_q`=1. `loadn_q` registers `loadn` every cycle in every state.
  - A press captures exactly once, however long `loadn` stays low.
  - A press reaching IDLE with `loadn` already low does not capture.
- Capture in IDLE, with `digit` ≤ 9, shifts left:
  - `min_tens`←`min_ones`, `min_ones`←`sec_tens`, `sec_tens`←`sec_ones`, `sec_ones`←`digit`.
  - The old `min_tens` is discarded.
  - `digit` > 9 is ignored. Captures outside IDLE are ignored.
- Entered `sec_tens` may be 6–9 (e.g. 00:90). It is not normalised; countdown handles it.
- States: IDLE, RUNNING, DONE.
- IDLE, priority `clearn` > capture > `startn`:
  - `clearn`=0: all digits ← 0. A coincident capture is discarded.
  - `startn`=0 with time ≠ 00:00 and no capture in the same cycle → RUNNING.
  - `startn` with time = 00:00 is ignored.
- RUNNING, priority `stopn` > `tick`:
  - `stopn`=0 → IDLE, time held (pause), no decrement even if `tick`=1.
  - `tick`=1: BCD decrement of MM:SS.
    - `sec_ones`>0: decrement it.
    - Otherwise `sec_ones`←9 and: `sec_tens`>0 → decrement it; else `sec_tens`←5 and borrow from minutes.
    - Minutes borrow the same way: `min_ones`>0 → decrement; else `min_ones`←9, `min_tens`−1.
  - If the decremented result is 00:00 → DONE on the same edge.
  - `clearn` and `startn` are ignored.
- DONE:
  - Time stays 00:00.
  - `clearn`=0 or `stopn`=0 → IDLE.
  - Captures and `startn` are ignored.
- Outputs:
  - `running` = (state==RUNNING); `done` = (state==DONE); `enablen` = (state≠IDLE).
  - All are registered and change only at clock edges.
- `resetn`=0 mid-run or mid-entry forces the reset values at that edge, regardless of other inputs.

## Timing
- Capture latency: the digits reflect the new key on the first edge that samples `loadn`=0 with `loadn_q`=1.
- Start: `running`=1 and `enablen`=1 after the edge that samples `startn`=0. The first decrement needs a later `tick`.
- A `tick` coinciding with the start edge is not applied.
- Decrement: new time is visible after the edge sampling `tick`=1.
- Reaching zero: `done`=1 and `running`=0 are asserted on the same edge as the final decrement.
- Stop/clear: take effect on the sampling edge; `enablen` falls on that same edge.
- No combinational input→output paths.

## Test plan
- Reset:
  - Drive random inputs, then assert `resetn`=0 for 1 cycle.
  - Expect digits 0000, `running`=0, `done`=0, `enablen`=0.
- Entry:
  - Press 1, 3, 0, each with `loadn` low for 5 cycles and high gaps → 01:30.
  - Then press `digit`=4'hC → still 01:30.
  - Then press 2,4,5,9,7 → 45:97. The oldest digit is dropped.
- Countdown to done:
  - Enter 2, assert `startn`, apply 2 ticks.
  - Expect 00:01, then 00:00 with `done`=1, `running`=0, `enablen`=1 on the second tick edge.
  - `clearn` → IDLE, `enablen`=0.
- Borrow:
  - From 01:00, 1 tick → 00:59.
  - From 10:00, 1 tick → 09:59.
  - From 00:90, 1 tick → 00:89.
- Pause and resume:
  - In RUNNING at 00:05, assert `stopn` and `tick` in the same cycle → IDLE, 00:05.
  - Press 1 → 00:51.
  - `startn`, then 1 tick → 00:50.
- Ignored requests:
  - `startn` at 00:00 → stays IDLE.
  - `clearn` during RUNNING → no effect.
  - In IDLE, `clearn` coincident with a press of 7 → 00:00.
  - A key held low across the stop edge is not captured afterwards.
